// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants shared by the VGA timing
// blocks, derived totals and sync windows, and a width-fit helper used for
// elaboration-time range checks.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Sync windows are [START, END).
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;      // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;    // 752
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;      // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;    // 492

  localparam int CNT_W    = 10;
  localparam bit SYNC_POL = 1'b0;

  // True when a counter that wraps at total-1 can be held in w bits.
  function automatic logic fits(input int total, input int w);
    return (total <= (1 << w));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. A wrap counter over VISIBLE+FRONT+SYNC+BACK
// positions plus sync/visible/blank decode.
//   clk, reset_n : clock, async active-low reset (count resets to TOTAL-1)
//   step         : advance one position this clk
//   cnt          : registered current position
//   wrap         : combinational, high when this step takes cnt TOTAL-1 -> 0
//   sync/visible/blank : combinational decode of the position cnt will hold
//                  after this clk, so a parent register stage lines up with cnt
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE  = 640,
  parameter int FRONT    = 16,
  parameter int SYNC     = 96,
  parameter int BACK     = 48,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync,
  output logic             visible,
  output logic             blank
);

  localparam int               TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [31:0]      VIS_END    = 32'(VISIBLE);
  localparam logic [31:0]      SYNC_START = 32'(VISIBLE + FRONT);
  localparam logic [31:0]      SYNC_END   = 32'(VISIBLE + FRONT + SYNC);

  if (!fits(TOTAL, CNT_W)) begin : g_bad_width
    $error("vga_axis_counter: TOTAL=%0d does not fit in CNT_W=%0d", TOTAL, CNT_W);
  end

  logic [CNT_W-1:0] nxt;
  logic [31:0]      nxt_w;   // widened so window ends equal to 2**CNT_W compare correctly

  assign wrap = step && (cnt == LAST);

  always_comb begin
    nxt = cnt;
    if (wrap)      nxt = '0;
    else if (step) nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= LAST;
    else          cnt <= nxt;
  end

  assign nxt_w   = 32'(nxt);
  assign visible = (nxt_w < VIS_END);
  assign blank   = ~visible;
  assign sync    = (nxt_w >= SYNC_START && nxt_w < SYNC_END) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator. Horizontal counter steps on pix_en,
// vertical counter steps on the horizontal wrap. All outputs are registered and
// describe the counters of the same cycle (no skew between px_x/px_y and decode).
//   clk, reset_n : clock, async active-low reset
//   pix_en       : pixel tick
//   hsync, vsync : sync pulses, level SYNC_POL while active
//   video_on     : inside the visible area
//   vblank       : px_y >= V_VISIBLE (level reference for frame-start detect)
//   line_end     : one clk high when px_x first shows 0 after an h wrap
//   px_x, px_y   : raw counts, not clamped; gate with video_on
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter bit SYNC_POL  = vga_timing_pkg::SYNC_POL,
  parameter int CNT_W     = vga_timing_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             vblank,
  output logic             line_end,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y
);

  logic h_wrap, h_sync, h_vis, h_blank;
  logic v_wrap, v_sync, v_vis, v_blank;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE), .FRONT (H_FRONT), .SYNC (H_SYNC), .BACK (H_BACK),
    .SYNC_POL(SYNC_POL),  .CNT_W (CNT_W)
  ) u_h (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (pix_en),
    .cnt    (px_x),
    .wrap   (h_wrap),
    .sync   (h_sync),
    .visible(h_vis),
    .blank  (h_blank)
  );

  // h_wrap already includes pix_en, so the vertical axis only moves on a real tick.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE), .FRONT (V_FRONT), .SYNC (V_SYNC), .BACK (V_BACK),
    .SYNC_POL(SYNC_POL),  .CNT_W (CNT_W)
  ) u_v (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (h_wrap),
    .cnt    (px_y),
    .wrap   (v_wrap),
    .sync   (v_sync),
    .visible(v_vis),
    .blank  (v_blank)
  );

  // Axis decode is taken from next-count values, so registering it here lands
  // in the same cycle as the counters themselves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b0;
      vblank   <= 1'b1;
      line_end <= 1'b0;
    end else begin
      hsync    <= h_sync;
      vsync    <= v_sync;
      video_on <= h_vis & v_vis;
      vblank   <= v_blank;
      line_end <= h_wrap;
    end
  end

  wire unused_axis = &{1'b0, v_wrap, h_blank};

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance for reset, line timing, half-rate
// pixel ticks and mid-line reset; reduced active-high instance for full frames.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Default 640x480 instance
  logic       reset_n = 1'b0;
  logic       pix_en  = 1'b0;
  logic       hsync, vsync, video_on, vblank, line_end;
  logic [9:0] px_x, px_y;

  vga_sync_gen dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .vblank(vblank),
    .line_end(line_end), .px_x(px_x), .px_y(px_y)
  );

  // Reduced timing, active-high sync: H 8/2/2/2 (14), V 4/1/1/1 (7)
  logic       s_reset_n = 1'b0;
  logic       s_pix_en  = 1'b0;
  logic       s_hsync, s_vsync, s_video_on, s_vblank, s_line_end;
  logic [3:0] s_px_x, s_px_y;

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .CNT_W(4)
  ) dut_s (
    .clk(clk), .reset_n(s_reset_n), .pix_en(s_pix_en),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on), .vblank(s_vblank),
    .line_end(s_line_end), .px_x(s_px_x), .px_y(s_px_y)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset;
    repeat (2) @(negedge clk);
    total_cnt++; if (px_x !== 10'd799) $display("FAIL reset_px_x got %0d want 799", px_x); else pass_cnt++;
    total_cnt++; if (px_y !== 10'd524) $display("FAIL reset_px_y got %0d want 524", px_y); else pass_cnt++;
    total_cnt++;
    if ({hsync, vsync, video_on, vblank, line_end} !== 5'b11010)
      $display("FAIL reset_flags got hs%b vs%b von%b vb%b le%b want 11010",
               hsync, vsync, video_on, vblank, line_end);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_first_tick;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    total_cnt++;
    if (px_x !== 10'd0 || px_y !== 10'd0) $display("FAIL first_pos got (%0d,%0d) want (0,0)", px_x, px_y);
    else pass_cnt++;
    total_cnt++;
    if ({hsync, vsync, video_on, vblank, line_end} !== 5'b11101)
      $display("FAIL first_flags got hs%b vs%b von%b vb%b le%b want 11101",
               hsync, vsync, video_on, vblank, line_end);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (px_x !== 10'd0 || px_y !== 10'd0 || line_end !== 1'b0 || video_on !== 1'b1)
      $display("FAIL idle_hold got (%0d,%0d) le%b von%b want (0,0) le0 von1", px_x, px_y, line_end, video_on);
    else pass_cnt++;
  endtask

  task automatic test_line;
    int hs_low = 0, first_low = -1, last_low = -1, le_cnt = 0, le_at = -1, von_cnt = 0, x_err = 0;
    pix_en = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (px_x !== 10'(k % 800)) x_err++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(px_x);
        last_low = int'(px_x);
      end
      if (line_end === 1'b1) begin le_cnt++; le_at = k; end
      if (video_on === 1'b1) von_cnt++;
    end
    pix_en = 1'b0;
    total_cnt++; if (x_err != 0) $display("FAIL line_px_x got %0d bad cycles want 0", x_err); else pass_cnt++;
    total_cnt++; if (hs_low != 96) $display("FAIL line_hsync_width got %0d want 96", hs_low); else pass_cnt++;
    total_cnt++;
    if (first_low != 656 || last_low != 751)
      $display("FAIL line_hsync_span got %0d..%0d want 656..751", first_low, last_low);
    else pass_cnt++;
    total_cnt++;
    if (le_cnt != 1 || le_at != 800) $display("FAIL line_end_once got cnt %0d at %0d want 1 at 800", le_cnt, le_at);
    else pass_cnt++;
    total_cnt++; if (von_cnt != 640) $display("FAIL line_video_on got %0d want 640", von_cnt); else pass_cnt++;
    total_cnt++;
    if (px_x !== 10'd0 || px_y !== 10'd1) $display("FAIL line_next_row got (%0d,%0d) want (0,1)", px_x, px_y);
    else pass_cnt++;
  endtask

  task automatic test_half_rate;
    int hold_err = 0, le_cnt = 0, le_at = -1, x_err = 0;
    logic [9:0] prev_x;
    for (int c = 0; c < 1600; c++) begin
      prev_x = px_x;
      pix_en = (c % 2 == 0);
      @(negedge clk);
      if (c % 2 == 1) begin
        if (px_x !== prev_x) hold_err++;
      end else if (px_x !== 10'((c / 2 + 1) % 800)) x_err++;
      if (line_end === 1'b1) begin le_cnt++; le_at = c; end
    end
    pix_en = 1'b0;
    total_cnt++; if (hold_err != 0) $display("FAIL half_hold got %0d moves want 0", hold_err); else pass_cnt++;
    total_cnt++; if (x_err != 0) $display("FAIL half_px_x got %0d bad ticks want 0", x_err); else pass_cnt++;
    total_cnt++;
    if (le_cnt != 1 || le_at != 1598) $display("FAIL half_line_end got cnt %0d at %0d want 1 at 1598", le_cnt, le_at);
    else pass_cnt++;
    total_cnt++;
    if (px_x !== 10'd0 || px_y !== 10'd2) $display("FAIL half_next_row got (%0d,%0d) want (0,2)", px_x, px_y);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    pix_en = 1'b1;
    repeat (700) @(negedge clk);
    total_cnt++;
    if (px_x !== 10'd700 || hsync !== 1'b0) $display("FAIL mid_pre got x%0d hs%b want x700 hs0", px_x, hsync);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (px_x !== 10'd799 || px_y !== 10'd524 || hsync !== 1'b1 || video_on !== 1'b0 || vblank !== 1'b1)
      $display("FAIL mid_async got (%0d,%0d) hs%b von%b vb%b want (799,524) hs1 von0 vb1",
               px_x, px_y, hsync, video_on, vblank);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (px_x !== 10'd799 || line_end !== 1'b0) $display("FAIL mid_held got x%0d le%b want x799 le0", px_x, line_end);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (px_x !== 10'd0 || px_y !== 10'd0 || hsync !== 1'b1 || video_on !== 1'b1)
      $display("FAIL mid_restart got (%0d,%0d) hs%b von%b want (0,0) hs1 von1", px_x, px_y, hsync, video_on);
    else pass_cnt++;
    pix_en = 1'b0;
  endtask

  task automatic test_small_frame;
    int hs_hi = 0, vs_hi = 0, le_cnt = 0, von_cnt = 0, vb_rise = 0, rise_x = -1, rise_y = -1;
    logic prev_vb;
    @(negedge clk);
    total_cnt++;
    if (s_px_x !== 4'd13 || s_px_y !== 4'd6 || s_hsync !== 1'b0 || s_vsync !== 1'b0 || s_vblank !== 1'b1)
      $display("FAIL small_reset got (%0d,%0d) hs%b vs%b vb%b want (13,6) hs0 vs0 vb1",
               s_px_x, s_px_y, s_hsync, s_vsync, s_vblank);
    else pass_cnt++;
    s_reset_n = 1'b1;
    s_pix_en  = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (s_px_x !== 4'd0 || s_px_y !== 4'd0 || s_video_on !== 1'b1 || s_hsync !== 1'b0)
      $display("FAIL small_first got (%0d,%0d) von%b hs%b want (0,0) von1 hs0", s_px_x, s_px_y, s_video_on, s_hsync);
    else pass_cnt++;
    prev_vb = s_vblank;
    for (int k = 1; k <= 98; k++) begin
      @(negedge clk);
      if (s_hsync === 1'b1) hs_hi++;
      if (s_vsync === 1'b1) vs_hi++;
      if (s_line_end === 1'b1) le_cnt++;
      if (s_video_on === 1'b1) von_cnt++;
      if (s_vblank === 1'b1 && prev_vb === 1'b0) begin
        vb_rise++; rise_x = int'(s_px_x); rise_y = int'(s_px_y);
      end
      prev_vb = s_vblank;
    end
    s_pix_en = 1'b0;
    total_cnt++; if (hs_hi != 14) $display("FAIL small_hsync got %0d want 14", hs_hi); else pass_cnt++;
    total_cnt++; if (vs_hi != 14) $display("FAIL small_vsync got %0d want 14", vs_hi); else pass_cnt++;
    total_cnt++; if (le_cnt != 7) $display("FAIL small_line_end got %0d want 7", le_cnt); else pass_cnt++;
    total_cnt++; if (von_cnt != 32) $display("FAIL small_video_on got %0d want 32", von_cnt); else pass_cnt++;
    total_cnt++;
    if (vb_rise != 1 || rise_x != 0 || rise_y != 4)
      $display("FAIL small_vblank_rise got %0d at (%0d,%0d) want 1 at (0,4)", vb_rise, rise_x, rise_y);
    else pass_cnt++;
    total_cnt++;
    if (s_px_x !== 4'd0 || s_px_y !== 4'd0 || s_vblank !== 1'b0)
      $display("FAIL small_wrap got (%0d,%0d) vb%b want (0,0) vb0", s_px_x, s_px_y, s_vblank);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_first_tick;
    test_line;
    test_half_rate;
    test_reset_mid;
    test_small_frame;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
